// File: rtl/insn_asm_pkg.sv
// Shared widths, immediate-type codes and request record for the instruction
// assembler and its immediate range checker.
package insn_asm_pkg;

    localparam int INSN_LEN       = 32;
    localparam int DATA_LEN       = 32;
    localparam int IMM_TYPE_WIDTH = 3;
    localparam int OPCODE_LEN     = 7;
    localparam int REG_SEL        = 5;
    localparam int FUNCT3_LEN     = 3;

    localparam logic [IMM_TYPE_WIDTH-1:0] IMM_I = 3'd0;
    localparam logic [IMM_TYPE_WIDTH-1:0] IMM_S = 3'd1;
    localparam logic [IMM_TYPE_WIDTH-1:0] IMM_U = 3'd2;
    localparam logic [IMM_TYPE_WIDTH-1:0] IMM_J = 3'd3;

    typedef struct packed {
        logic [IMM_TYPE_WIDTH-1:0] imm_type;
        logic [DATA_LEN-1:0]       imm;
        logic [OPCODE_LEN-1:0]     opcode;
        logic [REG_SEL-1:0]        rd;
        logic [FUNCT3_LEN-1:0]     funct3;
        logic [REG_SEL-1:0]        rs1;
        logic [REG_SEL-1:0]        rs2;
    } insn_req_t;

    // True when v[DATA_LEN-1:lsb] are all equal, i.e. v is a sign extension from bit lsb.
    function automatic logic upper_uniform(input logic [DATA_LEN-1:0] v,
                                           input int unsigned lsb);
        logic [DATA_LEN-1:0] s;
        s = $signed(v) >>> lsb;
        return (s == '0) || (s == '1);
    endfunction

endpackage

// File: rtl/insn_asm_range_chk.sv
// Combinational immediate encodability check; undefined immediate types are
// checked as I-type, matching how they are packed.
import insn_asm_pkg::*;

module imm_range_chk (
    input  logic [DATA_LEN-1:0]       i_imm,
    input  logic [IMM_TYPE_WIDTH-1:0] i_imm_type,
    output logic                      o_err
);

    always_comb begin
        o_err = 1'b0;
        case (i_imm_type)
            IMM_U:   o_err = (i_imm[11:0] != '0);
            IMM_J:   o_err = i_imm[0] | ~upper_uniform(i_imm, 20);
            default: o_err = ~upper_uniform(i_imm, 11);
        endcase
    end

endmodule

// File: rtl/insn_asm.sv
// Two-stage RV32I instruction assembler: S1 holds the request and range
// result, S2 holds the packed word. Valid/ready on both sides.
import insn_asm_pkg::*;

module insn_asm #(
    parameter int ERR_CNT_W = 16
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic [IMM_TYPE_WIDTH-1:0] in_imm_type,
    input  logic [DATA_LEN-1:0]       in_imm,
    input  logic [OPCODE_LEN-1:0]     in_opcode,
    input  logic [REG_SEL-1:0]        in_rd,
    input  logic [FUNCT3_LEN-1:0]     in_funct3,
    input  logic [REG_SEL-1:0]        in_rs1,
    input  logic [REG_SEL-1:0]        in_rs2,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [INSN_LEN-1:0]       out_inst,
    output logic                      out_err,
    output logic [ERR_CNT_W-1:0]      err_cnt
);

    logic                 w_adv;
    logic                 w_in_err;
    logic [INSN_LEN-1:0]  w_packed;

    logic                 r_s1_valid;
    insn_req_t            r_s1_req;
    logic                 r_s1_err;
    logic                 r_out_valid;
    logic [INSN_LEN-1:0]  r_out_inst;
    logic                 r_out_err;
    logic [ERR_CNT_W-1:0] r_err_cnt;

    // An empty S2 always accepts, so bubbles collapse even under backpressure.
    assign w_adv    = ~r_out_valid | out_ready;
    assign in_ready = ~r_s1_valid | w_adv;

    imm_range_chk u_range_chk (
        .i_imm      (in_imm),
        .i_imm_type (in_imm_type),
        .o_err      (w_in_err)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            r_s1_valid <= 1'b0;
            r_s1_req   <= '0;
            r_s1_err   <= 1'b0;
        end else if (in_ready) begin
            r_s1_valid <= in_valid;
            if (in_valid) begin
                r_s1_req <= '{imm_type: in_imm_type, imm: in_imm, opcode: in_opcode,
                              rd: in_rd, funct3: in_funct3, rs1: in_rs1, rs2: in_rs2};
                r_s1_err <= w_in_err;
            end
        end
    end

    always_comb begin
        w_packed = '0;
        case (r_s1_req.imm_type)
            IMM_S: w_packed = {r_s1_req.imm[11:5], r_s1_req.rs2, r_s1_req.rs1,
                               r_s1_req.funct3, r_s1_req.imm[4:0], r_s1_req.opcode};
            IMM_U: w_packed = {r_s1_req.imm[31:12], r_s1_req.rd, r_s1_req.opcode};
            IMM_J: w_packed = {r_s1_req.imm[20], r_s1_req.imm[10:1], r_s1_req.imm[11],
                               r_s1_req.imm[19:12], r_s1_req.rd, r_s1_req.opcode};
            default: w_packed = {r_s1_req.imm[11:0], r_s1_req.rs1, r_s1_req.funct3,
                                 r_s1_req.rd, r_s1_req.opcode};
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_out_valid <= 1'b0;
            r_out_inst  <= '0;
            r_out_err   <= 1'b0;
        end else if (w_adv) begin
            r_out_valid <= r_s1_valid;
            if (r_s1_valid) begin
                r_out_inst <= w_packed;
                r_out_err  <= r_s1_err;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_err_cnt <= '0;
        end else if (r_out_valid && out_ready && r_out_err && (r_err_cnt != '1)) begin
            r_err_cnt <= r_err_cnt + 1'b1;
        end
    end

    assign out_valid = r_out_valid;
    assign out_inst  = r_out_inst;
    assign out_err   = r_out_err;
    assign err_cnt   = r_err_cnt;

endmodule

// File: tb/tb_insn_asm.sv
// Bench for insn_asm: directed vectors, backpressure, reset, counter saturation
// and random traffic against an arithmetic reference model with decode round-trip.
import insn_asm_pkg::*;

module tb_insn_asm;

    logic        clk = 1'b0;
    logic        reset;
    logic        in_valid;
    logic        in_ready;
    logic [2:0]  in_imm_type;
    logic [31:0] in_imm;
    logic [6:0]  in_opcode;
    logic [4:0]  in_rd;
    logic [2:0]  in_funct3;
    logic [4:0]  in_rs1;
    logic [4:0]  in_rs2;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_inst;
    logic        out_err;
    logic [15:0] err_cnt;

    int tests = 0;
    int failed = 0;
    int delivered = 0;

    typedef struct {
        logic [31:0] inst;
        logic        err;
        logic [2:0]  t;
        logic [31:0] imm;
    } exp_t;

    exp_t        q[$];
    logic [15:0] m_cnt = '0;

    insn_asm #(.ERR_CNT_W(16)) dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
        .in_imm_type(in_imm_type), .in_imm(in_imm), .in_opcode(in_opcode),
        .in_rd(in_rd), .in_funct3(in_funct3), .in_rs1(in_rs1), .in_rs2(in_rs2),
        .out_valid(out_valid), .out_ready(out_ready), .out_inst(out_inst),
        .out_err(out_err), .err_cnt(err_cnt)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            failed++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Encodability from numeric ranges of the signed immediate.
    function automatic logic model_err(input logic [2:0] t, input logic [31:0] imm);
        longint s;
        s = longint'($signed(imm));
        case (t)
            IMM_U:   return (imm % 4096) != 0;
            IMM_J:   return ((imm % 2) != 0) || (s < -(64'sd1 <<< 20)) || (s > (64'sd1 <<< 20) - 1);
            default: return (s < -2048) || (s > 2047);
        endcase
    endfunction

    function automatic logic [31:0] model_inst(input logic [2:0] t, input logic [31:0] imm,
                                               input logic [6:0] op, input logic [4:0] rd,
                                               input logic [2:0] f3, input logic [4:0] rs1,
                                               input logic [4:0] rs2);
        logic [31:0] o, r, a, b, f;
        o = 32'(op); r = 32'(rd) << 7; a = 32'(rs1) << 15; b = 32'(rs2) << 20; f = 32'(f3) << 12;
        case (t)
            IMM_S: return (((imm >> 5) & 32'h7F) << 25) | b | a | f | ((imm & 32'h1F) << 7) | o;
            IMM_U: return (imm & 32'hFFFFF000) | r | o;
            IMM_J: return (((imm >> 20) & 32'h1) << 31) | (((imm >> 1) & 32'h3FF) << 21) |
                          (((imm >> 11) & 32'h1) << 20) | (((imm >> 12) & 32'hFF) << 12) | r | o;
            default: return ((imm & 32'hFFF) << 20) | a | f | r | o;
        endcase
    endfunction

    function automatic logic [31:0] decode(input logic [2:0] t, input logic [31:0] w);
        case (t)
            IMM_S:   return {{20{w[31]}}, w[31:25], w[11:7]};
            IMM_U:   return {w[31:12], 12'b0};
            IMM_J:   return {{11{w[31]}}, w[31], w[19:12], w[20], w[30:21], 1'b0};
            default: return {{20{w[31]}}, w[31:20]};
        endcase
    endfunction

    // Scoreboard: outputs are popped before the same cycle's accept is pushed.
    always @(negedge clk) begin
        exp_t e;
        if (reset) begin
            q.delete();
            m_cnt = '0;
        end else begin
            check("err_cnt", 32'(err_cnt), 32'(m_cnt));
            if (out_valid && out_ready) begin
                if (q.size() == 0) begin
                    tests++;
                    failed++;
                    $error("FAIL spurious_out: observed inst %h with nothing outstanding", out_inst);
                end else begin
                    e = q.pop_front();
                    check("sb_inst", out_inst, e.inst);
                    check("sb_err", 32'(out_err), 32'(e.err));
                    if (!e.err) check("roundtrip", decode(e.t, out_inst), e.imm);
                    if (e.err && m_cnt != 16'hFFFF) m_cnt = m_cnt + 16'd1;
                end
                delivered++;
            end
            if (in_valid && in_ready) begin
                e.t    = in_imm_type;
                e.imm  = in_imm;
                e.err  = model_err(in_imm_type, in_imm);
                e.inst = model_inst(in_imm_type, in_imm, in_opcode, in_rd, in_funct3, in_rs1, in_rs2);
                q.push_back(e);
            end
        end
    end

    task automatic drive(input logic [2:0] t, input logic [31:0] imm, input logic [6:0] op,
                         input logic [4:0] rd, input logic [2:0] f3, input logic [4:0] rs1,
                         input logic [4:0] rs2);
        in_imm_type = t; in_imm = imm; in_opcode = op; in_rd = rd;
        in_funct3 = f3; in_rs1 = rs1; in_rs2 = rs2;
    endtask

    // Single request into an idle pipeline with out_ready high.
    task automatic send(input string tag, input logic [2:0] t, input logic [31:0] imm,
                        input logic [6:0] op, input logic [4:0] rd, input logic [2:0] f3,
                        input logic [4:0] rs1, input logic [4:0] rs2,
                        input logic [31:0] exp_inst, input logic exp_err);
        drive(t, imm, op, rd, f3, rs1, rs2);
        in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        check({tag, "_lat1"}, 32'(out_valid), 32'd0);
        @(posedge clk); #1;
        check({tag, "_lat2"}, 32'(out_valid), 32'd1);
        check({tag, "_inst"}, out_inst, exp_inst);
        check({tag, "_err"}, 32'(out_err), 32'(exp_err));
        @(posedge clk); #1;
    endtask

    initial begin
        int acc, c, stalls, d0, mode;
        bit saw_stall, rdy_s;
        logic [31:0] r;

        reset = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
        drive(IMM_I, '0, '0, '0, '0, '0, '0);
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_out_inst", out_inst, 32'd0);
        check("rst_out_err", 32'(out_err), 32'd0);
        check("rst_err_cnt", 32'(err_cnt), 32'd0);
        check("rst_in_ready", 32'(in_ready), 32'd1);

        send("I_neg1", IMM_I, 32'hFFFFFFFF, 7'h13, 5'd1, 3'd0, 5'd0, 5'd0, 32'hFFF00093, 1'b0);
        send("S_8", IMM_S, 32'd8, 7'h23, 5'd0, 3'd2, 5'd3, 5'd2, 32'h0021A423, 1'b0);
        send("U_12345", IMM_U, 32'h12345000, 7'h37, 5'd5, 3'd0, 5'd0, 5'd0, 32'h123452B7, 1'b0);
        send("J_800", IMM_J, 32'h800, 7'h6F, 5'd1, 3'd0, 5'd0, 5'd0, 32'h001000EF, 1'b0);
        check("cnt_before_err", 32'(err_cnt), 32'd0);
        send("J_801", IMM_J, 32'h801, 7'h6F, 5'd1, 3'd0, 5'd0, 5'd0, 32'h001000EF, 1'b1);
        check("cnt_after_J_err", 32'(err_cnt), 32'd1);
        send("I_800", IMM_I, 32'h800, 7'h13, 5'd1, 3'd0, 5'd0, 5'd0, 32'h80000093, 1'b1);
        check("cnt_after_I_err", 32'(err_cnt), 32'd2);
        send("undef_type", 3'd5, 32'h123, 7'h13, 5'd2, 3'd1, 5'd4, 5'd0, 32'h12321113, 1'b0);
        send("I_max", IMM_I, 32'h7FF, 7'h13, 5'd0, 3'd0, 5'd0, 5'd0, 32'h7FF00013, 1'b0);
        send("I_min", IMM_I, 32'hFFFFF800, 7'h13, 5'd0, 3'd0, 5'd0, 5'd0, 32'h80000013, 1'b0);
        send("I_below", IMM_I, 32'hFFFFF7FF, 7'h13, 5'd0, 3'd0, 5'd0, 5'd0, 32'h7FF00013, 1'b1);
        send("J_min", IMM_J, 32'hFFF00000, 7'h6F, 5'd0, 3'd0, 5'd0, 5'd0, 32'h8000006F, 1'b0);
        send("J_max", IMM_J, 32'h000FFFFE, 7'h6F, 5'd0, 3'd0, 5'd0, 5'd0, 32'h7FFFF06F, 1'b0);
        send("J_over", IMM_J, 32'h00100000, 7'h6F, 5'd0, 3'd0, 5'd0, 5'd0, 32'h8000006F, 1'b1);
        send("U_low", IMM_U, 32'h12345001, 7'h37, 5'd0, 3'd0, 5'd0, 5'd0, 32'h12345037, 1'b1);

        // Backpressure: six back-to-back requests, consumer stalled in cycles 3..6.
        acc = 0; c = 0; saw_stall = 0; d0 = delivered;
        while (acc < 6 && c < 40) begin
            c++;
            out_ready = !(c >= 3 && c <= 6);
            drive(IMM_I, 32'(acc * 16), 7'h13, 5'(acc + 1), 3'd0, 5'd0, 5'd0);
            in_valid = 1'b1;
            @(negedge clk);
            rdy_s = in_ready;
            if (!rdy_s) saw_stall = 1;
            @(posedge clk); #1;
            if (rdy_s) acc++;
        end
        in_valid = 1'b0; out_ready = 1'b1;
        c = 0;
        while (delivered - d0 < 6 && c < 20) begin
            @(posedge clk); #1;
            c++;
        end
        check("bp_accepted", 32'(acc), 32'd6);
        check("bp_delivered", 32'(delivered - d0), 32'd6);
        check("bp_stall_seen", 32'(saw_stall), 32'd1);

        // Full rate with the consumer always ready.
        stalls = 0; d0 = delivered;
        for (int i = 0; i < 20; i++) begin
            drive(IMM_I, 32'(i), 7'h13, 5'(i), 3'd0, 5'd1, 5'd0);
            in_valid = 1'b1;
            @(negedge clk);
            if (!in_ready) stalls++;
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("fullrate_stalls", 32'(stalls), 32'd0);
        check("fullrate_delivered", 32'(delivered - d0), 32'd20);

        // Random traffic; a stalled request is held until accepted.
        rdy_s = 1;
        for (int i = 0; i < 400; i++) begin
            if (!(in_valid && !rdy_s)) begin
                in_valid = ($urandom % 4) != 0;
                mode = $urandom % 4;
                r = $urandom;
                case (mode)
                    0: in_imm = r;
                    1: in_imm = {{20{r[11]}}, r[11:0]};
                    2: in_imm = {{11{r[20]}}, r[20:1], 1'b0};
                    default: in_imm = r & 32'hFFFFF000;
                endcase
                in_imm_type = 3'($urandom % 4);
                in_opcode = 7'($urandom); in_rd = 5'($urandom); in_funct3 = 3'($urandom);
                in_rs1 = 5'($urandom); in_rs2 = 5'($urandom);
            end
            out_ready = ($urandom % 4) != 0;
            @(negedge clk);
            rdy_s = in_ready;
            @(posedge clk); #1;
        end
        in_valid = 1'b0; out_ready = 1'b1;
        c = 0;
        while (q.size() != 0 && c < 20) begin
            @(posedge clk); #1;
            c++;
        end
        check("rand_drained", 32'(q.size()), 32'd0);

        // Reset with both stages occupied.
        out_ready = 1'b0;
        drive(IMM_I, 32'h800, 7'h13, 5'd3, 3'd0, 5'd0, 5'd0);
        in_valid = 1'b1;
        repeat (2) @(posedge clk);
        #1 in_valid = 1'b0;
        check("full_out_valid", 32'(out_valid), 32'd1);
        check("full_in_ready", 32'(in_ready), 32'd0);
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        check("midrst_out_valid", 32'(out_valid), 32'd0);
        check("midrst_err_cnt", 32'(err_cnt), 32'd0);
        check("midrst_in_ready", 32'(in_ready), 32'd1);
        out_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1 check("midrst_no_output", 32'(out_valid), 32'd0);

        // Drive the error counter to saturation, then keep erroring.
        drive(IMM_I, 32'h800, 7'h13, 5'd1, 3'd0, 5'd0, 5'd0);
        in_valid = 1'b1;
        c = 0;
        while (err_cnt != 16'hFFFF && c < 70000) begin
            @(posedge clk); #1;
            c++;
        end
        check("sat_reached", 32'(err_cnt), 32'h0000FFFF);
        repeat (5) @(posedge clk);
        #1 in_valid = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        check("sat_hold", 32'(err_cnt), 32'h0000FFFF);
        check("sat_drained", 32'(q.size()), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule

// File: doc/insn_asm.md
# insn_asm

Instruction assembler: the encode direction of the immediate path. It accepts an opcode, register fields, a 32-bit immediate and an immediate type (`IMM_I`/`IMM_S`/`IMM_U`/`IMM_J`), and produces the packed 32-bit RV32I instruction word. It also flags immediates that cannot be encoded. It sits on the debug/instruction-injection path feeding the fetch-side injection queue, and is also the round-trip checker partner for the decode-side immediate generator. Two-stage pipeline, valid/ready on both sides, one instruction per cycle.

## Interface
Parameters:
- `ERR_CNT_W`, 16: width of the saturating error counter.

Ports:
- `clk`  in  1  clock; all logic on rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `in_valid`  in  1  request valid.
- `in_ready`  out  1  request accepted when `in_valid && in_ready`.
- `in_imm_type`  in  `IMM_TYPE_WIDTH`  `IMM_I`/`IMM_S`/`IMM_U`/`IMM_J`.
- `in_imm`  in  `DATA_LEN`  full-width signed immediate value (not pre-shifted).
- `in_opcode`  in  7  inst[6:0].
- `in_rd`  in  5  destination register (I/U/J).
- `in_funct3`  in  3  inst[14:12] (I/S).
- `in_rs1`  in  5  source 1 (I/S).
- `in_rs2`  in  5  source 2 (S).
- `out_valid`  out  1  result valid.
- `out_ready`  in  1  consumer accepts when `out_valid && out_ready`.
- `out_inst`  out  `INSN_LEN`  packed instruction.
- `out_err`  out  1  immediate not encodable for the given type.
- `err_cnt`  out  `ERR_CNT_W`  count of errored results delivered.

## Operation
- Stage 1 (S1): registers the request and computes `err` with the range checker.
- Stage 2 (S2): registers the packed word and `err`; S2 drives `out_*`.
- Range rules (`err`=1 when violated):
  - I and S: `in_imm[31:11]` all equal.
  - U: `in_imm[11:0]` == 0.
  - J: `in_imm[0]` == 0 and `in_imm[31:20]` all equal.
- Packing (unused fields are 0):
  - I: {imm[11:0], rs1, funct3, rd, opcode}.
  - S: {imm[11:5], rs2, rs1, funct3, imm[4:0], opcode}.
  - U: {imm[31:12], rd, opcode}.
  - J: {imm[20], imm[10:1], imm[11], imm[19:12], rd, opcode}.
  - An undefined `in_imm_type` value encodes as I.
- Errored requests are still packed from the truncated fields. They are delivered with `out_err`=1 and are never dropped.
- `err_cnt` increments on each output handshake with `out_err`=1 and saturates at all-ones.
- Round-trip invariant: when `out_err`=0, decoding `out_inst` with the same `imm_type` returns `in_imm` exactly.

## Timing
- Latency: 2 cycles from input handshake to `out_valid`, with no stalls. Throughput is 1 per cycle.
- Advance rules:
  - S2 loads when `!out_valid || out_ready`.
  - S1 advances under the same condition.
  - `in_ready = !s1_valid || !out_valid || out_ready`. This is combinational from `out_ready`; there is no combinational path from `in_*` to `out_*`.
- Bubbles collapse: an empty S2 accepts from S1 even while `out_ready`=0.
- Stability: while `out_valid && !out_ready`, `out_inst`/`out_err` stay stable and no input is lost. Output order equals input order.
- Reset: `s1_valid`, `out_valid`, `out_err` = 0; `out_inst` = 0; `err_cnt` = 0. Reset mid-flight discards both stages. `in_ready` = 1 in the first cycle after reset.
- Simultaneous input accept and output handshake in the same cycle is legal and sustains full rate.
- `err_cnt` saturation: a handshake at all-ones holds the value.

## Structure
- `constants.vh` (shared):
  - Existing: `INSN_LEN`, `DATA_LEN`, `IMM_TYPE_WIDTH`, `IMM_I/S/U/J`.
  - New: `OPCODE_LEN` (7), `REG_SEL` (5), `FUNCT3_LEN` (3).
- One combinational sub-module, `imm_range_chk` (imm, imm_type -> err), shared with the injection-queue assertion logic.
- Packing is inline in `insn_asm`.

## Test plan
- I-type: opcode 0x13, rd 1, rs1 0, funct3 0, imm 0xFFFFFFFF -> `out_inst` 0xFFF00093, `out_err` 0, valid 2 cycles after accept.
- S-type: opcode 0x23, funct3 2, rs1 3, rs2 2, imm 8 -> 0x0021A423. U-type: opcode 0x37, rd 5, imm 0x12345000 -> 0x123452B7.
- J-type: opcode 0x6F, rd 1, imm 0x800 -> 0x001000EF. Same with imm 0x801 -> `out_err` 1; `err_cnt` 0 -> 1 on handshake.
- I-type imm 0x800 -> `out_err` 1. Preload `err_cnt` to 0xFFFF via repeated errors -> stays 0xFFFF.
- Backpressure: 6 back-to-back requests with `out_ready` low for cycles 3-6 -> `in_ready` drops once both stages are full. All 6 are delivered in order with no duplicates; full rate resumes.
- Assert `reset` with both stages full -> next cycle `out_valid` 0, `err_cnt` 0, `in_ready` 1. Random round-trip: decode(`out_inst`) == `in_imm` whenever `out_err`=0.
